// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- MIPS instruction-decode stage.
//
// This stage takes each instruction word returned for the PC that fetch
// issued. It decodes the fields, reads the 32x32 register file and drives a
// registered ID/EX bundle to execute. It also detects load-use hazards and
// stalls fetch. Writeback from the last stage enters through the wb_* port.
//
// Internally there are two register levels:
//   ID latch : insn / pc / valid captured from fetch
//   ID/EX    : every output except stall_out
//
// Ports
//   clk_in, rst_n_in        stage clock, asynchronous active-low reset
//   insn_in, pc_in          instruction word and its PC from fetch/memory
//   insn_valid_in           insn_in/pc_in valid this cycle
//   stall_in                downstream stall, freezes the whole stage
//   wb_en_in/addr/data      register-file write port
//   stall_out               combinational stall to fetch (hazard | stall_in)
//   valid_out .. jump_out   registered ID/EX bundle
//
// Build option
//   DECODE_WB_BYPASS_EN  when defined, a same-cycle writeback to rs/rt is
//                        forwarded into rs_data_out/rt_data_out. Otherwise the
//                        new value is visible one edge later.
// ---------------------------------------------------------------------------
module decode #(
    parameter logic [31:0] NOP_INSN = 32'h0000_0000,
    parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] insn_in,
    input  logic [31:0] pc_in,
    input  logic        insn_valid_in,
    input  logic        stall_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] insn_out,
    output logic [5:0]  opcode_out,
    output logic [5:0]  funct_out,
    output logic [4:0]  shamt_out,
    output logic [4:0]  rs_addr_out,
    output logic [4:0]  rt_addr_out,
    output logic [4:0]  dest_addr_out,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        branch_out,
    output logic        jump_out
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  dest_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } idex_t;

    // ID latch
    logic [31:0] insn_q, insn_d;
    logic [31:0] pc_q,   pc_d;
    logic        vld_q,  vld_d;

    // ID/EX register
    idex_t idex_q, idex_d, dec, bubble;

    logic [31:0] rf_q [32];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt, hazard;
    logic [31:0] rs_rdata, rt_rdata, imm_ext;
    logic signed [15:0] imm_s;
    logic signed [31:0] imm_sext;

    assign op  = insn_q[31:26];
    assign rs  = insn_q[25:21];
    assign rt  = insn_q[20:16];
    assign rd  = insn_q[15:11];

    // Only andi/ori/xori zero-extend; everything else (lui included) sign-extends.
    assign imm_s    = insn_q[15:0];
    assign imm_sext = imm_s;
    assign imm_ext  = (op >= 6'h0C && op <= 6'h0E) ? {16'h0000, insn_q[15:0]} : imm_sext;

    // Register-file read; r0 is hardwired to zero.
    always_comb begin
        rs_rdata = (rs == 5'd0) ? 32'h0 : rf_q[rs];
        rt_rdata = (rt == 5'd0) ? 32'h0 : rf_q[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en_in && wb_addr_in != 5'd0 && wb_addr_in == rs) rs_rdata = wb_data_in;
        if (wb_en_in && wb_addr_in != 5'd0 && wb_addr_in == rt) rt_rdata = wb_data_in;
`endif
    end

    // rt is a true source only for R-type, beq/bne and sw; for I-type ALU ops
    // and lw it is the destination and must not trigger a stall.
    assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    assign hazard  = valid_out && mem_read_out && (dest_addr_out != 5'd0) &&
                     ((dest_addr_out == rs) || ((dest_addr_out == rt) && uses_rt));
    assign stall_out = hazard | stall_in;

    always_comb begin
        dec           = '0;
        dec.valid     = vld_q;
        dec.pc        = pc_q;
        dec.insn      = insn_q;
        dec.opcode    = op;
        dec.funct     = insn_q[5:0];
        dec.shamt     = insn_q[10:6];
        dec.rs_addr   = rs;
        dec.rt_addr   = rt;
        dec.rs_data   = rs_rdata;
        dec.rt_data   = rt_rdata;
        dec.imm       = imm_ext;
        // Invalid latch contents leave every control bit and dest at zero.
        if (vld_q) begin
            case (op)
                6'h00: begin
                    if (insn_q[5:0] == 6'h08) begin
                        dec.jump = 1'b1;
                    end else begin
                        dec.reg_write = 1'b1;
                        dec.dest_addr = rd;
                    end
                end
                6'h02: dec.jump = 1'b1;
                6'h03: begin
                    dec.jump      = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.dest_addr = 5'd31;
                end
                6'h04, 6'h05: dec.branch = 1'b1;
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                    dec.reg_write = 1'b1;
                    dec.dest_addr = rt;
                end
                6'h23: begin
                    dec.mem_read  = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.dest_addr = rt;
                end
                6'h2B: dec.mem_write = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bubble      = '0;
        bubble.insn = NOP_INSN;
        if (stall_in) begin
            idex_d = idex_q;
            insn_d = insn_q;
            pc_d   = pc_q;
            vld_d  = vld_q;
        end else if (hazard) begin
            idex_d = bubble;
            insn_d = insn_q;
            pc_d   = pc_q;
            vld_d  = vld_q;
        end else begin
            idex_d = dec;
            insn_d = insn_in;
            pc_d   = pc_in;
            vld_d  = insn_valid_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            insn_q <= NOP_INSN;
            pc_q   <= RESET_PC;
            vld_q  <= 1'b0;
            idex_q <= '0;
        end else begin
            insn_q <= insn_d;
            pc_q   <= pc_d;
            vld_q  <= vld_d;
            idex_q <= idex_d;
        end
    end

    // Writeback commits even while the stage is stalled.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
        end else if (wb_en_in && wb_addr_in != 5'd0) begin
            rf_q[wb_addr_in] <= wb_data_in;
        end
    end

    assign valid_out     = idex_q.valid;
    assign pc_out        = idex_q.pc;
    assign insn_out      = idex_q.insn;
    assign opcode_out    = idex_q.opcode;
    assign funct_out     = idex_q.funct;
    assign shamt_out     = idex_q.shamt;
    assign rs_addr_out   = idex_q.rs_addr;
    assign rt_addr_out   = idex_q.rt_addr;
    assign dest_addr_out = idex_q.dest_addr;
    assign rs_data_out   = idex_q.rs_data;
    assign rt_data_out   = idex_q.rt_data;
    assign imm_out       = idex_q.imm;
    assign reg_write_out = idex_q.reg_write;
    assign mem_read_out  = idex_q.mem_read;
    assign mem_write_out = idex_q.mem_write;
    assign branch_out    = idex_q.branch;
    assign jump_out      = idex_q.jump;

endmodule
